// File: rtl/pipe_stage_if.sv
// Stage-to-stage bundle for one pipeline register: upstream beat, downstream beat and flush.
// A beat moves on a rising edge where valid && ready; valid never waits on ready, and payload is only meaningful while valid is high.
interface pipe_stage_if #(
    parameter int CTRL_W = 64,
    parameter int DATA_W = 256
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    // master: the surrounding pipeline (upstream stage, hazard logic, downstream stage)
    modport master (
        output in_valid, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );

    // slave: the stage register itself
    modport slave (
        input  in_valid, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, bubble-inserting flush and saturating stall/flush counters.
module pipe_stage_reg #(
    parameter int CTRL_W = 64,
    parameter int DATA_W = 256,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_if.slave      bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
    logic              in_ready_q;
    logic              in_ready;
    logic              m_valid;
    logic              accept;
    logic              consume;

    assign m_valid = (state_q != EMPTY);
    // With a skid slot, ready comes straight from a flop so out_ready never reaches in_ready.
    assign in_ready = (SKID != 0) ? in_ready_q : (!m_valid || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign consume  = m_valid && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = m_valid;
    assign bus.out_ctrl  = m_valid ? m_ctrl_q : '0;
    assign bus.out_data  = m_data_q;
    assign dbg_state     = state_q;

    always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d  = ONE;
                    m_ctrl_d = bus.in_ctrl;
                    m_data_d = bus.in_data;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    m_ctrl_d = bus.in_ctrl;
                    m_data_d = bus.in_data;
                end else if (accept) begin
                    // Only reachable with SKID=1: the head stalls, so the new beat parks in S.
                    state_d  = FULL;
                    s_ctrl_d = bus.in_ctrl;
                    s_data_d = bus.in_data;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    state_d  = ONE;
                    m_ctrl_d = s_ctrl_q;
                    m_data_d = s_data_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush turns everything held into a bubble; data fields are left as they were.
        if (bus.flush) begin
            state_d  = EMPTY;
            m_ctrl_d = '0;
            s_ctrl_d = '0;
            m_data_d = m_data_q;
            s_data_d = s_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            m_ctrl_q   <= '0;
            m_data_q   <= '0;
            s_ctrl_q   <= '0;
            s_data_q   <= '0;
            in_ready_q <= 1'b1;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            m_ctrl_q   <= m_ctrl_d;
            m_data_q   <= m_data_d;
            s_ctrl_q   <= s_ctrl_d;
            s_data_q   <= s_data_d;
            in_ready_q <= (state_d != FULL);
            if (m_valid && !bus.out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            // S valid implies M valid, so M alone tells whether the flush killed a beat.
            if (bus.flush && m_valid && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 instance (4-bit counters) and a SKID=0 instance,
// checked with a vector table, hand sequences and a queue-based random model.
module tb_pipe_stage_reg;
  localparam int CW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] stall1, flush1;
  logic [7:0] stall0, flush0;
  logic [1:0] dbg1, dbg0;
  int n_checks = 0;
  int n_fail = 0;

  pipe_stage_if #(.CTRL_W(CW), .DATA_W(DW)) if1 ();
  pipe_stage_if #(.CTRL_W(CW), .DATA_W(DW)) if0 ();

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .bus(if1),
    .stall_cnt(stall1), .flush_cnt(flush1), .dbg_state(dbg1)
  );
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .bus(if0),
    .stall_cnt(stall0), .flush_cnt(flush0), .dbg_state(dbg0)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  function automatic logic [DW-1:0] data_of(input logic [CW-1:0] c);
    return {~c, c};
  endfunction

  task automatic drive(input bit k, input bit iv, input logic [CW-1:0] c,
                       input logic [DW-1:0] d, input bit ordy, input bit fl);
    if1.in_valid = 1'b0; if1.in_ctrl = '0; if1.in_data = '0; if1.out_ready = 1'b1; if1.flush = 1'b0;
    if0.in_valid = 1'b0; if0.in_ctrl = '0; if0.in_data = '0; if0.out_ready = 1'b1; if0.flush = 1'b0;
    if (k) begin
      if1.in_valid = iv; if1.in_ctrl = c; if1.in_data = d; if1.out_ready = ordy; if1.flush = fl;
    end else begin
      if0.in_valid = iv; if0.in_ctrl = c; if0.in_data = d; if0.out_ready = ordy; if0.flush = fl;
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  logic [CW+DW-1:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Random run against a reference model: the stage is a FIFO of capacity 1 (SKID=0) or
  // 2 (SKID=1); flush empties it; counters count events and saturate.
  task automatic rand_run(input bit k, input int n);
    bit iv, ordy, fl, accept, consume, exp_ov, exp_ir, ready_reg;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic act_ov, act_ir;
    logic [CW-1:0] act_c;
    logic [DW-1:0] act_d;
    int stall_m, flush_m, maxc;
    exp_q.delete();
    ready_reg = 1'b1;
    stall_m = 0;
    flush_m = 0;
    maxc = k ? 15 : 255;
    for (int i = 0; i < n; i++) begin
      iv = ($urandom_range(0, 2) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 15) == 0);
      c = CW'($urandom_range(0, 255));
      d = DW'($urandom_range(0, 65535));
      drive(k, iv, c, d, ordy, fl);
      #1;
      act_ov = k ? if1.out_valid : if0.out_valid;
      act_ir = k ? if1.in_ready : if0.in_ready;
      act_c = k ? if1.out_ctrl : if0.out_ctrl;
      act_d = k ? if1.out_data : if0.out_data;
      exp_ov = (exp_q.size() > 0);
      exp_ir = k ? ready_reg : (exp_q.size() == 0 || ordy);
      check("rnd_out_valid", 32'(act_ov), 32'(exp_ov));
      check("rnd_in_ready", 32'(act_ir), 32'(exp_ir));
      if (exp_ov) begin
        check("rnd_out_ctrl", 32'(act_c), 32'(exp_q[0][CW+DW-1:DW]));
        check("rnd_out_data", 32'(act_d), 32'(exp_q[0][DW-1:0]));
      end else begin
        check("rnd_out_ctrl_bubble", 32'(act_c), 32'd0);
      end
      check("rnd_stall_cnt", k ? 32'(stall1) : 32'(stall0), 32'(stall_m));
      check("rnd_flush_cnt", k ? 32'(flush1) : 32'(flush0), 32'(flush_m));
      accept = iv && exp_ir;
      consume = exp_ov && ordy;
      if (exp_ov && !ordy && stall_m < maxc) stall_m++;
      if (fl && exp_q.size() > 0 && flush_m < maxc) flush_m++;
      if (fl) begin
        exp_q.delete();
      end else begin
        if (consume) void'(exp_q.pop_front());
        if (accept) exp_q.push_back({c, d});
      end
      ready_reg = (exp_q.size() < 2);
      tick();
    end
  endtask

  // ---------------- vector table (SKID=1) ----------------
  typedef struct {
    logic iv; logic [CW-1:0] c; logic ordy; logic fl;
    logic ov; logic [CW-1:0] oc; logic ir; logic [3:0] st; logic [3:0] fc;
  } vec_t;
  vec_t tbl[16];

  initial begin
    //           iv    c      ordy  fl    ov    oc     ir    st     fc
    tbl[0]  = '{1'b1, 8'h0A, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 4'd0};
    tbl[1]  = '{1'b1, 8'h0B, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 4'd0, 4'd0};
    tbl[2]  = '{1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b0, 4'd1, 4'd0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b0, 4'd2, 4'd0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0A, 1'b0, 4'd3, 4'd0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0B, 1'b1, 4'd3, 4'd0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd3, 4'd0};
    tbl[7]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd3, 4'd0};
    tbl[8]  = '{1'b1, 8'h0B, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 4'd3, 4'd0};
    tbl[9]  = '{1'b1, 8'h0C, 1'b0, 1'b1, 1'b1, 8'h0A, 1'b0, 4'd4, 4'd0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd5, 4'd1};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 4'd5, 4'd1};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd5, 4'd1};
    tbl[13] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd5, 4'd1};
    tbl[14] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 4'd5, 4'd1};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd5, 4'd2};
  end

  // ---------------- test sequence ----------------
  initial begin
    drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    do_reset();
    #1;
    check("rst_out_valid", 32'(if1.out_valid), 32'd0);
    check("rst_out_ctrl", 32'(if1.out_ctrl), 32'd0);
    check("rst_out_data", 32'(if1.out_data), 32'd0);
    check("rst_in_ready", 32'(if1.in_ready), 32'd1);
    check("rst_stall_cnt", 32'(stall1), 32'd0);
    check("rst_flush_cnt", 32'(flush1), 32'd0);
    check("rst0_out_valid", 32'(if0.out_valid), 32'd0);
    check("rst0_out_data", 32'(if0.out_data), 32'd0);

    // Streaming 1..8 with out_ready high: one-cycle latency, no stalls.
    for (int i = 0; i <= 8; i++) begin
      drive(1'b1, i < 8, CW'(i + 1), data_of(CW'(i + 1)), 1'b1, 1'b0);
      #1;
      check("stream_out_valid", 32'(if1.out_valid), 32'(i > 0));
      check("stream_out_ctrl", 32'(if1.out_ctrl), 32'(i));
      check("stream_in_ready", 32'(if1.in_ready), 32'd1);
      tick();
    end
    #1;
    check("stream_stall_cnt", 32'(stall1), 32'd0);

    // Backpressure, flush-FULL, flush-empty and flush-with-consume vectors.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, tbl[i].iv, tbl[i].c, data_of(tbl[i].c), tbl[i].ordy, tbl[i].fl);
      #1;
      check($sformatf("vec%0d_out_valid", i), 32'(if1.out_valid), 32'(tbl[i].ov));
      check($sformatf("vec%0d_out_ctrl", i), 32'(if1.out_ctrl), 32'(tbl[i].oc));
      check($sformatf("vec%0d_in_ready", i), 32'(if1.in_ready), 32'(tbl[i].ir));
      check($sformatf("vec%0d_stall_cnt", i), 32'(stall1), 32'(tbl[i].st));
      check($sformatf("vec%0d_flush_cnt", i), 32'(flush1), 32'(tbl[i].fc));
      if (tbl[i].ov)
        check($sformatf("vec%0d_out_data", i), 32'(if1.out_data), 32'(data_of(tbl[i].oc)));
      tick();
    end

    // Reset in the middle of FULL drops both beats, ignores beats offered during reset.
    do_reset();
    drive(1'b1, 1'b1, 8'h33, data_of(8'h33), 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'h44, data_of(8'h44), 1'b0, 1'b0);
    tick();
    #1;
    check("full_in_ready", 32'(if1.in_ready), 32'd0);
    drive(1'b1, 1'b1, 8'h55, data_of(8'h55), 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    check("midrst_out_valid", 32'(if1.out_valid), 32'd0);
    check("midrst_out_ctrl", 32'(if1.out_ctrl), 32'd0);
    check("midrst_out_data", 32'(if1.out_data), 32'd0);
    check("midrst_in_ready", 32'(if1.in_ready), 32'd1);
    check("midrst_flush_cnt", 32'(flush1), 32'd0);
    check("midrst_stall_cnt", 32'(stall1), 32'd0);

    // 20 stall cycles saturate the 4-bit stall counter at 15.
    drive(1'b1, 1'b1, 8'h66, data_of(8'h66), 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    #1;
    check("sat_stall_cnt", 32'(stall1), 32'd15);
    check("sat_out_ctrl", 32'(if1.out_ctrl), 32'h66);
    drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    #1;
    check("sat_drain_out_valid", 32'(if1.out_valid), 32'd0);
    check("sat_hold_stall_cnt", 32'(stall1), 32'd15);

    // SKID=0: held beat, 3 cycles of backpressure, combinational in_ready.
    do_reset();
    drive(1'b0, 1'b1, 8'h77, data_of(8'h77), 1'b1, 1'b0);
    #1;
    check("s0_empty_in_ready", 32'(if0.in_ready), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'h88, data_of(8'h88), 1'b0, 1'b0);
      #1;
      check("s0_bp_in_ready", 32'(if0.in_ready), 32'd0);
      check("s0_bp_out_ctrl", 32'(if0.out_ctrl), 32'h77);
      check("s0_bp_out_data", 32'(if0.out_data), 32'(data_of(8'h77)));
      tick();
    end
    drive(1'b0, 1'b1, 8'h88, data_of(8'h88), 1'b1, 1'b0);
    #1;
    check("s0_release_in_ready", 32'(if0.in_ready), 32'd1);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    check("s0_next_out_ctrl", 32'(if0.out_ctrl), 32'h88);
    check("s0_next_out_valid", 32'(if0.out_valid), 32'd1);
    tick();
    #1;
    check("s0_drain_out_valid", 32'(if0.out_valid), 32'd0);
    check("s0_stall_cnt", 32'(stall0), 32'd3);

    // Randomized runs against the queue model.
    do_reset();
    rand_run(1'b1, 600);
    do_reset();
    rand_run(1'b0, 600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB), replacing fixed-field stage latches with one generic payload register. Adds a valid/ready handshake, an optional 2-entry skid buffer that breaks the combinational ready path, and a flush that turns held instructions into bubbles. It also provides saturating stall and flush performance counters. Each stage instance sits between two pipeline stages; hazard/branch logic drives `flush`, and the downstream stage drives `out_ready`.

## Interface
Parameters:
- `CTRL_W`, 64: control payload width (IR + decoded signal bits); zeroed on flush.
- `DATA_W`, 256: data payload width (PC, operands, ALU result, ext, dst/pos fields); never zeroed by flush.
- `SKID`, 1: 0 = single register, combinational ready; 1 = 2-entry skid buffer, registered ready.
- `CNT_W`, 16: performance counter width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream offers a beat.
- `in_ready` out 1: stage can accept a beat this cycle.
- `in_ctrl` in CTRL_W: control payload.
- `in_data` in DATA_W: data payload.
- `flush` in 1: kill all held beats and any beat accepted this cycle.
- `out_valid` out 1: head beat valid.
- `out_ready` in 1: downstream consumes the head beat.
- `out_ctrl` out CTRL_W: head control payload; 0 whenever `out_valid` = 0.
- `out_data` out DATA_W: head data payload.
- `stall_cnt` out CNT_W: cycles with `out_valid && !out_ready`.
- `flush_cnt` out CNT_W: flush cycles that killed at least one beat.

## Operation
- Transfer rules: accept when `in_valid && in_ready`; consume when `out_valid && out_ready`. Beats leave in arrival order; none is duplicated or lost except by flush.
- SKID=0:
  - One register `M`; `in_ready = !M.valid || out_ready` (combinational).
  - On accept, `M` loads the input. On consume without accept, `M.valid` goes to 0.
- SKID=1:
  - Registers `M` (head) and `S` (skid); `in_ready = !S.valid`, driven from a flop.
  - States:
    - EMPTY (M=0, S=0).
    - ONE (M=1, S=0).
    - FULL (M=1, S=1).
  - Transitions:
    - EMPTY + accept → ONE.
    - ONE + accept + consume → ONE, with the new beat in M.
    - ONE + accept + no consume → FULL, with the new beat in S.
    - ONE + consume only → EMPTY.
    - FULL + consume → ONE, with S moved to M. There is no accept, since `in_ready` = 0.
    - FULL + no consume → FULL, and held payloads do not change.
- Flush, which has priority over all other updates:
  - Next state is EMPTY: all valid bits cleared and stored ctrl zeroed.
  - Stored data is left unchanged.
  - A beat accepted in the flush cycle completes its handshake and is discarded.
  - A consume in the flush cycle still completes; the downstream stage sees that beat.
- Counters:
  - Saturate at 2^CNT_W−1 with no wrap.
  - `stall_cnt` increments in every cycle where `out_valid && !out_ready`, including flush cycles.
  - `flush_cnt` increments when `flush` is high and M.valid or S.valid is 1.
- Reset:
  - `out_valid` = 0, `out_ctrl` = 0, `out_data` = 0, S cleared, and both counters = 0.
  - For SKID=1, `in_ready` = 1 from the first cycle after `rst` is deasserted.
  - Beats offered while `rst` is high are ignored.
  - Reset mid-operation drops all held beats without incrementing `flush_cnt`.

## Timing
- Latency: an accepted beat appears on `out_*` in the next cycle. There is no combinational input→output path for payload or `in_valid`.
- SKID=0 throughput: 1 beat/cycle; `in_ready` depends combinationally on `out_ready`.
- SKID=1 throughput: 1 beat/cycle while `out_ready` = 1. After `out_ready` drops, one more beat is absorbed, and `in_ready` falls the cycle after that.
- SKID=1 `in_ready` is a flop output with no combinational path from `out_ready`.
- Flush in cycle t: `out_valid` = 0 and `out_ctrl` = 0 in cycle t+1. For SKID=1, `in_ready` = 1 in cycle t+1.
- Counter values reflect events up to the previous edge, with a 1-cycle lag.

## Test plan
- Streaming, SKID=1: feed ctrl=1..8 with `out_ready`=1 → out_ctrl=1..8 in order, 1-cycle latency, `stall_cnt`=0.
- Backpressure, SKID=1:
  - Stimulus: drop `out_ready` with beat A held and B offered.
  - Response: B goes to skid and `in_ready`=0 next cycle.
  - Stimulus: raise `out_ready`.
  - Response: A then B emerge with no loss; `stall_cnt` equals the number of low cycles.
- Flush FULL: M=0xA, S=0xB, flush=1 with in_valid (0xC) → next cycle `out_valid`=0, `out_ctrl`=0, 0xC never emitted, `in_ready`=1, `flush_cnt`=1.
- Flush while empty: no change to state, `flush_cnt` stays 0.
- SKID=0: 3 cycles of `out_ready`=0 with a beat held → `in_ready`=0 in the same cycles and the payload held stable.
- Counters and reset:
  - Stimulus: CNT_W=4, 20 stall cycles.
  - Response: `stall_cnt`=15.
  - Stimulus: `rst` pulse mid-FULL.
  - Response: all outputs 0 next cycle, `flush_cnt` unchanged at 0.
